// File: rtl/jogador_automatico.sv
// Automatic player: records the LED sequence the game shows and replays it on the buttons.
// Optional fault injection (forca_erro port) is built only when ERRO_INJETADO_EN is defined.
module jogador_automatico #(
  parameter int HOLD_CICLOS  = 5,
  parameter int PAUSA_CICLOS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       vez_jogador,
  input  logic       nova_jogada,
  input  logic       pronto,
`ifdef ERRO_INJETADO_EN
  input  logic       forca_erro,
`endif
  output logic [3:0] botoes,
  output logic [3:0] db_estado,
  output logic [4:0] db_tamanho,
  output logic       db_overflow,
  output logic       db_erro
);

  typedef enum logic [3:0] {
    OCIOSO         = 4'd0,
    CAPTURA        = 4'd1,
    PRESSIONA      = 4'd2,
    SOLTA          = 4'd3,
    PROXIMA        = 4'd4,
    NOVA_PRESSIONA = 4'd5,
    NOVA_SOLTA     = 4'd6,
    AGUARDA_FIM    = 4'd7
  } estado_t;

  localparam logic [7:0] HOLD_FIM  = 8'(HOLD_CICLOS - 1);
  localparam logic [7:0] PAUSA_FIM = 8'(PAUSA_CICLOS - 1);

  estado_t    estado;
  logic [3:0] leds_ant;
  logic       vez_ant;
  logic [4:0] indice;
  logic [7:0] contador;
  logic [3:0] memoria [16];

  logic       borda_leds, subida_vez, aborta, captura_ok, erro_ativo;
  logic [4:0] tamanho_ef, prox_indice;
  logic [3:0] prox_entrada;

  assign borda_leds = (leds != 4'b0000) && (leds_ant == 4'b0000);
  assign subida_vez = vez_jogador && !vez_ant;
  assign aborta     = pronto || !habilita;
  assign captura_ok = (estado == CAPTURA) && !aborta && borda_leds && (db_tamanho != 5'd16);
  // Length including a capture happening this cycle, so a coincident vez rise sees it.
  assign tamanho_ef = db_tamanho + 5'(captura_ok);
  assign db_estado  = estado;

`ifdef ERRO_INJETADO_EN
  logic forca_reg;
  always_ff @(posedge clock) begin
    if (reset)
      forca_reg <= 1'b0;
    else if (estado == CAPTURA && subida_vez)
      forca_reg <= forca_erro;
  end
  assign erro_ativo = (estado == CAPTURA) ? forca_erro : forca_reg;
`else
  assign erro_ativo = 1'b0;
`endif

  // NOTE: every always_comb output gets a value on the first line, so no path can infer a latch.
  always_comb begin
    prox_indice  = (estado == CAPTURA) ? 5'd0 : indice + 5'd1;
    prox_entrada = (captura_ok && prox_indice == db_tamanho) ? leds : memoria[prox_indice[3:0]];
    if (erro_ativo && prox_indice == tamanho_ef - 5'd1)
      prox_entrada = {prox_entrada[2:0], prox_entrada[3]};
  end

  // NOTE: the sequence store is plain RAM with no reset; only db_tamanho says which entries are valid.
  always_ff @(posedge clock) begin
    if (captura_ok)
      memoria[db_tamanho[3:0]] <= leds;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      botoes      <= 4'b0000;
      db_tamanho  <= 5'd0;
      indice      <= 5'd0;
      contador    <= 8'd0;
      db_overflow <= 1'b0;
      db_erro     <= 1'b0;
      leds_ant    <= 4'b0000;
      vez_ant     <= 1'b0;
    end else begin
      leds_ant <= leds;
      vez_ant  <= vez_jogador;
      if (aborta) begin
        estado   <= OCIOSO;
        botoes   <= 4'b0000;
        contador <= 8'd0;
        indice   <= 5'd0;
      end else begin
        case (estado)
          OCIOSO: begin
            estado     <= CAPTURA;
            db_tamanho <= 5'd0;
          end
          CAPTURA: begin
            if (captura_ok)
              db_tamanho <= tamanho_ef;
            else if (borda_leds)
              db_overflow <= 1'b1;
            if (subida_vez) begin
              contador <= 8'd0;
              indice   <= 5'd0;
              if (tamanho_ef != 5'd0) begin
                estado <= PRESSIONA;
                botoes <= prox_entrada;
              end else if (nova_jogada) begin
                estado <= NOVA_PRESSIONA;
                botoes <= 4'b0001;
              end else begin
                estado  <= AGUARDA_FIM;
                db_erro <= 1'b1;
              end
            end
          end
          PRESSIONA, NOVA_PRESSIONA: begin
            if (contador == HOLD_FIM) begin
              estado   <= (estado == PRESSIONA) ? SOLTA : NOVA_SOLTA;
              botoes   <= 4'b0000;
              contador <= 8'd0;
            end else begin
              contador <= contador + 8'd1;
            end
          end
          SOLTA, NOVA_SOLTA: begin
            if (contador == PAUSA_FIM) begin
              estado   <= (estado == SOLTA) ? PROXIMA : AGUARDA_FIM;
              contador <= 8'd0;
            end else begin
              contador <= contador + 8'd1;
            end
          end
          PROXIMA: begin
            if (prox_indice < db_tamanho) begin
              estado <= PRESSIONA;
              indice <= prox_indice;
              botoes <= prox_entrada;
            end else if (nova_jogada) begin
              estado <= NOVA_PRESSIONA;
              botoes <= 4'b0001;
            end else begin
              estado <= AGUARDA_FIM;
            end
          end
          AGUARDA_FIM: begin
            if (!vez_jogador) begin
              estado     <= CAPTURA;
              db_tamanho <= 5'd0;
            end
          end
          default: begin
            estado <= OCIOSO;
            botoes <= 4'b0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: capture vector table plus a replay scoreboard.
// Define ERRO_INJETADO_EN for both files to exercise the fault-injection path.
module tb_jogador_automatico;

  localparam int HOLD  = 5;
  localparam int PAUSA = 5;

  logic       clock = 1'b0;
  logic       reset, habilita, vez_jogador, nova_jogada, pronto;
  logic [3:0] leds;
  logic [3:0] botoes, db_estado;
  logic [4:0] db_tamanho;
  logic       db_overflow, db_erro;
`ifdef ERRO_INJETADO_EN
  logic       forca_erro = 1'b0;
`endif

  jogador_automatico #(.HOLD_CICLOS(HOLD), .PAUSA_CICLOS(PAUSA)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .leds        (leds),
    .vez_jogador (vez_jogador),
    .nova_jogada (nova_jogada),
    .pronto      (pronto),
`ifdef ERRO_INJETADO_EN
    .forca_erro  (forca_erro),
`endif
    .botoes      (botoes),
    .db_estado   (db_estado),
    .db_tamanho  (db_tamanho),
    .db_overflow (db_overflow),
    .db_erro     (db_erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] b;
    logic [3:0] st;
  } exp_t;

  typedef struct {
    logic [3:0] leds;
    logic [4:0] tam;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    tests++;
    if (atual !== esperado) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] b, input logic [3:0] st, input int n);
    exp_t e;
    e.b  = b;
    e.st = st;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic push_entry(input logic [3:0] e);
    push(e, 4'd2, HOLD);
    push(4'd0, 4'd3, PAUSA);
    push(4'd0, 4'd4, 1);
  endtask

  // Drains the scoreboard one cycle per entry; optionally echoes presses on leds.
  task automatic run_sb(input bit echo);
    exp_t e;
    int k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step();
      check("replay botoes", botoes, e.b);
      check("replay estado", db_estado, e.st);
      if (echo) leds = (k % 3 == 0) ? 4'b0010 : 4'b0000;
      k++;
    end
  endtask

  task automatic capture(input logic [3:0] cor);
    leds = cor;
    step();
    leds = 4'b0000;
    step();
  endtask

  initial begin
    vecs[0] = '{4'b0001, 5'd1};
    vecs[1] = '{4'b0000, 5'd1};
    vecs[2] = '{4'b0100, 5'd2};
    vecs[3] = '{4'b0100, 5'd2};
    vecs[4] = '{4'b0000, 5'd2};
    vecs[5] = '{4'b1000, 5'd3};
    vecs[6] = '{4'b0010, 5'd3};
    vecs[7] = '{4'b0000, 5'd3};

    reset = 1'b1; habilita = 1'b0; leds = 4'b0000;
    vez_jogador = 1'b0; nova_jogada = 1'b0; pronto = 1'b0;
    step();
    step();
    check("reset estado", db_estado, 0);
    check("reset botoes", botoes, 0);
    check("reset tamanho", db_tamanho, 0);
    check("reset overflow", db_overflow, 0);
    check("reset erro", db_erro, 0);

    reset = 1'b0; habilita = 1'b1;
    step();
    check("enable to CAPTURA", db_estado, 1);

    // Three colours, one held colour and one direct colour change
    foreach (vecs[i]) begin
      leds = vecs[i].leds;
      step();
      check("capture tamanho", db_tamanho, vecs[i].tam);
      check("capture estado", db_estado, 1);
    end
    vez_jogador = 1'b1;
    push_entry(4'b0001);
    push_entry(4'b0100);
    push_entry(4'b1000);
    push(4'd0, 4'd7, 3);
    run_sb(1'b1);
    check("echo ignored tamanho", db_tamanho, 3);
    vez_jogador = 1'b0; leds = 4'b0000;
    step();
    check("back to CAPTURA", db_estado, 1);
    check("tamanho cleared", db_tamanho, 0);

    // One capture plus the extra new play
    capture(4'b0010);
    check("single capture", db_tamanho, 1);
    nova_jogada = 1'b1; vez_jogador = 1'b1;
    push_entry(4'b0010);
    push(4'b0001, 4'd5, HOLD);
    push(4'd0, 4'd6, PAUSA);
    push(4'd0, 4'd7, 2);
    run_sb(1'b0);
    vez_jogador = 1'b0; nova_jogada = 1'b0;
    step();
    check("nova done estado", db_estado, 1);

    // Capture edge in the same cycle as the vez rise
    leds = 4'b0100; vez_jogador = 1'b1;
    push_entry(4'b0100);
    push(4'd0, 4'd7, 2);
    run_sb(1'b0);
    check("coincident capture", db_tamanho, 1);
    vez_jogador = 1'b0; leds = 4'b0000;
    step();

    // Empty sequence without a new-play request
    vez_jogador = 1'b1;
    step();
    check("empty estado", db_estado, 7);
    check("empty erro", db_erro, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty botoes", botoes, 0);
    end
    vez_jogador = 1'b0;
    step();
    check("empty back CAPTURA", db_estado, 1);

    // Seventeen edges into a sixteen-entry store
    for (int i = 0; i < 17; i++) capture(4'(1 << (i % 4)));
    check("overflow tamanho", db_tamanho, 16);
    check("overflow flag", db_overflow, 1);
    vez_jogador = 1'b1;
    for (int i = 0; i < 16; i++) push_entry(4'(1 << (i % 4)));
    push(4'd0, 4'd7, 2);
    run_sb(1'b0);
    vez_jogador = 1'b0;
    step();

    // pronto during the second press
    capture(4'b0001);
    capture(4'b1000);
    vez_jogador = 1'b1;
    push_entry(4'b0001);
    push(4'b1000, 4'd2, 2);
    run_sb(1'b0);
    pronto = 1'b1;
    step();
    check("pronto estado", db_estado, 0);
    check("pronto botoes", botoes, 0);
    pronto = 1'b0; vez_jogador = 1'b0;
    step();
    check("pronto recover", db_estado, 1);
    check("pronto tamanho", db_tamanho, 0);

    // Reset while in SOLTA
    capture(4'b0100);
    vez_jogador = 1'b1;
    push(4'b0100, 4'd2, HOLD);
    push(4'd0, 4'd3, 2);
    run_sb(1'b0);
    reset = 1'b1;
    step();
    check("midreset estado", db_estado, 0);
    check("midreset botoes", botoes, 0);
    check("midreset tamanho", db_tamanho, 0);
    check("midreset overflow", db_overflow, 0);
    check("midreset erro", db_erro, 0);
    reset = 1'b0; vez_jogador = 1'b0;
    step();
    check("after reset estado", db_estado, 1);

`ifdef ERRO_INJETADO_EN
    capture(4'b0001);
    capture(4'b1000);
    forca_erro = 1'b1; vez_jogador = 1'b1;
    push_entry(4'b0001);
    push_entry(4'b0001);
    push(4'd0, 4'd7, 2);
    run_sb(1'b0);
    forca_erro = 1'b0; vez_jogador = 1'b0;
    step();
`endif

    habilita = 1'b0;
    step();
    check("disable estado", db_estado, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter HOLD_CICLOS, default 5: cycles a button stays pressed per play (range 1..255).
REQ-002 Parameter PAUSA_CICLOS, default 5: cycles buttons stay released between plays (range 1..255).
REQ-003 clock  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 habilita  input  1  enables the automatic player; 0 forces idle.
REQ-006 leds  input  4  one-hot LED bus driven by the game; all-zero means dark.
REQ-007 vez_jogador  input  1  game signals that the player's turn is active.
REQ-008 nova_jogada  input  1  game requests one extra new play after the sequence.
REQ-009 pronto  input  1  game over; aborts the player.
REQ-010 botoes  output  4  one-hot button presses presented to the game.
REQ-011 db_estado  output  4  current FSM state encoding.
REQ-012 db_tamanho  output  5  number of captured sequence entries (0..16).
REQ-013 db_overflow  output  1  sticky: a capture was dropped because the sequence store was full.
REQ-014 db_erro  output  1  sticky: turn began with an empty sequence and no new-play request.

Function
REQ-015 Sequence store SHALL be 16 entries x 4 bits, written only in CAPTURA.
REQ-016 Capture edge SHALL be leds nonzero in the current cycle with leds all-zero in the previous cycle (one internal delay register); the current leds value is stored at index db_tamanho and db_tamanho increments.
REQ-017 A repeated colour SHALL be captured only if separated by at least one dark cycle; a direct nonzero-to-nonzero change SHALL NOT be captured.
REQ-018 A capture edge with db_tamanho = 16 SHALL be dropped and set db_overflow; db_tamanho SHALL NOT wrap.
REQ-019 The vez_jogador rising edge SHALL be vez_jogador = 1 now and 0 in the previous cycle.
REQ-020 States (encoding): OCIOSO 0, CAPTURA 1, PRESSIONA 2, SOLTA 3, PROXIMA 4, NOVA_PRESSIONA 5, NOVA_SOLTA 6, AGUARDA_FIM 7.
REQ-021 OCIOSO: habilita = 1 moves to CAPTURA with db_tamanho cleared.
REQ-022 CAPTURA on vez_jogador rise: db_tamanho > 0 moves to PRESSIONA with index 0; else nova_jogada = 1 moves to NOVA_PRESSIONA; else AGUARDA_FIM and db_erro set.
REQ-023 A capture edge coinciding with the vez_jogador rise SHALL be stored before the replay decision.
REQ-024 PRESSIONA: botoes = entry[index] for exactly HOLD_CICLOS cycles, then SOLTA.
REQ-025 SOLTA: botoes = 0 for exactly PAUSA_CICLOS cycles, then PROXIMA.
REQ-026 PROXIMA (1 cycle, botoes = 0): index+1 < db_tamanho moves to PRESSIONA with index+1; otherwise nova_jogada = 1 moves to NOVA_PRESSIONA, else AGUARDA_FIM.
REQ-027 NOVA_PRESSIONA: botoes = 4'b0001 for HOLD_CICLOS cycles, then NOVA_SOLTA for PAUSA_CICLOS cycles with botoes = 0, then AGUARDA_FIM.
REQ-028 AGUARDA_FIM: vez_jogador = 0 moves to CAPTURA with db_tamanho cleared.
REQ-029 botoes SHALL be a Moore output: first press appears in the cycle after the edge where the vez_jogador rise was detected; botoes = 0 in all other states.
REQ-030 pronto = 1 or habilita = 0 in any state SHALL move to OCIOSO on the next edge; pronto has priority over all other transitions.
REQ-031 leds activity outside CAPTURA (including echoes of the player's own presses) SHALL be ignored.

Reset
REQ-032 reset SHALL set state OCIOSO, botoes 0, db_tamanho 0, index 0, hold/gap counters 0, db_overflow 0, db_erro 0, leds/vez_jogador delay registers 0.
REQ-033 Sequence store contents SHALL NOT be reset; reset mid-replay SHALL drop botoes to 0 on the same edge.

Configuration
REQ-034 Macro ERRO_INJETADO_EN defined: input forca_erro (1 bit) exists, sampled at the vez_jogador rise; if 1, the last replayed sequence entry is rotated left by one (4'b1000 -> 4'b0001); the new play is never altered.
REQ-035 ERRO_INJETADO_EN undefined: port forca_erro absent; replay is always exact.

Verification
REQ-036 leds 0001,0,0100,0,1000,0 then vez_jogador rise -> botoes 0001, 0100, 1000, each 5 cycles high with 5-cycle gaps; db_tamanho = 3; state 7 at end.
REQ-037 One capture of 0010, nova_jogada = 1 at vez rise -> botoes 0010 (5 cycles), gap, 0001 (5 cycles), then AGUARDA_FIM.
REQ-038 17 capture edges -> db_tamanho = 16, db_overflow = 1, replay of 16 entries only.
REQ-039 vez rise with no captures and nova_jogada = 0 -> db_erro = 1, botoes stays 0, state 7.
REQ-040 pronto = 1 during second PRESSIONA -> next cycle state 0, botoes 0; reset mid-SOLTA -> all REQ-032 values.
REQ-041 ERRO_INJETADO_EN defined, sequence 0001,1000, forca_erro = 1 -> botoes 0001 then 0001 (rotated 1000).
